// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller with multicycle unit handshakes and held exception redirect
//   clk, resetn       : clock, synchronous active-low reset
//   stall_req         : per-stage stall requests
//   ex_rmem, ex_rt    : load in EX and its destination register
//   id_rs, id_rt      : decode source registers
//   unit_op/ready     : multicycle op present in EX / unit result valid
//   excepttype/cp0_epc: exception code from MEM and ERET return address
//   stall, flush      : per-stage hold / bubble controls
//   unit_start/abort  : one-cycle pulses to each multicycle unit
//   redirect_valid/pc : PC redirect request and target
module pipe_hazard_ctrl #(
    parameter int          NSTAGE    = 5,
    parameter int          ID_STAGE  = 1,
    parameter int          EX_STAGE  = 2,
    parameter int          MEM_STAGE = 3,
    parameter int          NUNIT     = 2,
    parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE = 32'h0000000e
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              ex_rmem,
    input  logic [4:0]        ex_rt,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [NUNIT-1:0]  unit_op,
    input  logic [NUNIT-1:0]  unit_ready,
    input  logic [31:0]       excepttype,
    input  logic [31:0]       cp0_epc,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic [NUNIT-1:0]  unit_start,
    output logic [NUNIT-1:0]  unit_abort,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc
);
    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
    logic [NUNIT-1:0][1:0] state;
    logic                  pend;
    logic [31:0]           pend_pc;
    logic                  accept, load_use;
    logic [31:0]           target;
    logic [NSTAGE-1:0]     src, stall_c, flush_c;
    logic [NUNIT-1:0]      start_c, abort_c, unit_stall;
    always_comb begin
        accept   = excepttype != 32'd0 && stall_req[NSTAGE-1:MEM_STAGE] == '0;
        load_use = ex_rmem && ex_rt != 5'd0 && (ex_rt == id_rs || ex_rt == id_rt);
        target   = excepttype == ERET_CODE ? cp0_epc : EXC_VEC;
        for (int u = 0; u < NUNIT; u++) begin
            start_c[u]    = state[u] == S_IDLE && unit_op[u] && !accept;
            abort_c[u]    = state[u] == S_BUSY && accept;
            unit_stall[u] = start_c[u] || state[u] == S_BUSY;
        end
        src           = stall_req;
        src[ID_STAGE] = src[ID_STAGE] | load_use;
        src[EX_STAGE] = src[EX_STAGE] | (|unit_stall);
        // a source at stage k holds every stage at or before k
        for (int i = 0; i < NSTAGE; i++)
            stall_c[i] = |(src >> i);
        // a held redirect must keep IF moving so the new PC gets loaded
        if (pend)
            stall_c[0] = 1'b0;
        if (accept)
            stall_c = '0;
        flush_c = {stall_c[NSTAGE-2:0] & ~stall_c[NSTAGE-1:1], pend};
        if (accept)
            flush_c = '1;
        stall          = resetn ? stall_c : '0;
        flush          = resetn ? flush_c : '0;
        unit_start     = resetn ? start_c : '0;
        unit_abort     = resetn ? abort_c : '0;
        redirect_valid = resetn && (accept || pend);
        redirect_pc    = !resetn ? 32'd0 : accept ? target : pend_pc;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int u = 0; u < NUNIT; u++)
                state[u] <= S_IDLE;
            pend    <= 1'b0;
            pend_pc <= 32'd0;
        end else begin
            // DONE waits for the op to leave EX so it is never restarted
            for (int u = 0; u < NUNIT; u++)
                state[u] <= accept ? S_IDLE :
                            start_c[u] ? S_BUSY :
                            state[u] == S_BUSY && unit_ready[u] ? S_DONE :
                            state[u] == S_DONE && !stall_c[EX_STAGE] ? S_IDLE : state[u];
            pend <= (accept || pend) && stall_req[0];
            if (accept && stall_req[0])
                pend_pc <= target;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and light random stimulus against a stage-depth model of the hazard controller
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b1;
    logic        resetn = 1'b0;
    logic [4:0]  stall_req = '0;
    logic        ex_rmem = 1'b0;
    logic [4:0]  ex_rt = '0, id_rs = '0, id_rt = '0;
    logic [1:0]  unit_op = '0, unit_ready = '0;
    logic [31:0] excepttype = '0, cp0_epc = '0;
    logic [4:0]  stall, flush;
    logic [1:0]  unit_start, unit_abort;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    pipe_hazard_ctrl dut (
        .clk(clk), .resetn(resetn), .stall_req(stall_req), .ex_rmem(ex_rmem),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .unit_op(unit_op),
        .unit_ready(unit_ready), .excepttype(excepttype), .cp0_epc(cp0_epc),
        .stall(stall), .flush(flush), .unit_start(unit_start), .unit_abort(unit_abort),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    // model state: per-unit "op in flight" and "result held while op still in EX"
    logic [1:0]  m_busy = '0, m_done = '0;
    logic        m_pend = 1'b0;
    logic [31:0] m_ppc = '0;
    // model outputs for the current cycle
    logic [4:0]  e_stall = '0, e_flush = '0;
    logic [1:0]  e_start = '0, e_abort = '0;
    logic        e_rv = 1'b0, acc = 1'b0;
    logic [31:0] e_rpc = '0, e_tgt = '0;
    // hand-computed literal expectations for the current cycle
    logic        lit_on = 1'b0, l_rv = 1'b0;
    logic [4:0]  l_stall = '0, l_flush = '0;
    logic [1:0]  l_start = '0, l_abort = '0;
    logic [31:0] l_rpc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin : cmp
        int  kmax;
        logic lu;
        acc   = resetn && excepttype != 0 && stall_req[4:3] == 2'b00;
        e_tgt = excepttype == 32'he ? cp0_epc : 32'hBFC00380;
        lu    = ex_rmem && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        kmax  = -1;
        for (int k = 0; k < 5; k++) if (stall_req[k]) kmax = k;
        if (lu && kmax < 1) kmax = 1;
        for (int u = 0; u < 2; u++) begin
            e_start[u] = resetn && !m_busy[u] && !m_done[u] && unit_op[u] && !acc;
            if ((m_busy[u] || e_start[u]) && kmax < 2) kmax = 2;
        end
        e_stall = '0;
        e_flush = '0;
        for (int i = 0; i < 5; i++) if (i <= kmax) e_stall[i] = 1'b1;
        if (kmax >= 0 && kmax < 4) e_flush[kmax+1] = 1'b1;
        if (m_pend) begin
            e_stall[0] = 1'b0;
            e_flush[1] = 1'b0;
            e_flush[0] = 1'b1;
        end
        e_abort = acc ? m_busy : 2'b00;
        if (acc) begin
            e_stall = '0;
            e_flush = 5'h1f;
        end
        e_rv  = acc || m_pend;
        e_rpc = acc ? e_tgt : m_ppc;
        if (!resetn) begin
            e_stall = '0; e_flush = '0; e_abort = '0; e_rv = 1'b0; e_rpc = '0;
        end
        check("stall", 32'(stall), 32'(e_stall));
        check("flush", 32'(flush), 32'(e_flush));
        check("unit_start", 32'(unit_start), 32'(e_start));
        check("unit_abort", 32'(unit_abort), 32'(e_abort));
        check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        if (e_rv || !resetn) check("redirect_pc", redirect_pc, e_rpc);
        if (lit_on) begin
            check("lit_stall", 32'(stall), 32'(l_stall));
            check("lit_flush", 32'(flush), 32'(l_flush));
            check("lit_start", 32'(unit_start), 32'(l_start));
            check("lit_abort", 32'(unit_abort), 32'(l_abort));
            check("lit_rv", 32'(redirect_valid), 32'(l_rv));
            if (l_rv) check("lit_pc", redirect_pc, l_rpc);
        end
    end

    always @(posedge clk) begin
        if (!resetn) begin
            m_busy = '0; m_done = '0; m_pend = 1'b0; m_ppc = '0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (acc) begin
                    m_busy[u] = 1'b0; m_done[u] = 1'b0;
                end else if (e_start[u]) m_busy[u] = 1'b1;
                else if (m_busy[u] && unit_ready[u]) begin
                    m_busy[u] = 1'b0; m_done[u] = 1'b1;
                end else if (m_done[u] && !e_stall[2]) m_done[u] = 1'b0;
            end
            if (acc) begin
                m_pend = stall_req[0];
                if (stall_req[0]) m_ppc = e_tgt;
            end else if (!stall_req[0]) m_pend = 1'b0;
        end
    end

    task automatic cyc(input bit chk, input logic [4:0] s, input logic [4:0] f,
                       input logic [1:0] st, input logic [1:0] ab, input bit rv, input logic [31:0] pc);
        lit_on = chk; l_stall = s; l_flush = f; l_start = st; l_abort = ab; l_rv = rv; l_rpc = pc;
        @(posedge clk);
        #1;
        lit_on = 1'b0;
    endtask

    task automatic tick();
        cyc(0, '0, '0, '0, '0, 0, '0);
    endtask

    initial begin
        cyc(1, '0, '0, '0, '0, 0, '0);
        cyc(1, '0, '0, '0, '0, 0, '0);
        resetn = 1'b1;
        cyc(1, '0, '0, '0, '0, 0, '0);
        // load-use
        ex_rmem = 1; ex_rt = 5; id_rs = 5;
        cyc(1, 5'b00011, 5'b00100, '0, '0, 0, '0);
        ex_rt = 0;
        cyc(1, '0, '0, '0, '0, 0, '0);
        id_rs = 0; id_rt = 7; ex_rt = 7;
        cyc(1, 5'b00011, 5'b00100, '0, '0, 0, '0);
        ex_rmem = 0;
        cyc(1, '0, '0, '0, '0, 0, '0);
        // divide, ready after 4 cycles
        unit_op = 2'b01;
        cyc(1, 5'b00111, 5'b01000, 2'b01, '0, 0, '0);
        repeat (3) cyc(1, 5'b00111, 5'b01000, '0, '0, 0, '0);
        unit_ready = 2'b01;
        cyc(1, 5'b00111, 5'b01000, '0, '0, 0, '0);
        unit_ready = 2'b00;
        cyc(1, '0, '0, '0, '0, 0, '0);
        unit_op = 2'b00;
        cyc(1, '0, '0, '0, '0, 0, '0);
        // result held in DONE under a D-bus stall
        unit_op = 2'b01; stall_req = 5'b01000;
        cyc(1, 5'b01111, 5'b10000, 2'b01, '0, 0, '0);
        tick();
        unit_ready = 2'b01;
        cyc(1, 5'b01111, 5'b10000, '0, '0, 0, '0);
        unit_ready = 2'b00;
        repeat (4) cyc(1, 5'b01111, 5'b10000, '0, '0, 0, '0);
        stall_req = '0;
        cyc(1, '0, '0, '0, '0, 0, '0);
        unit_op = 2'b00;
        tick();
        // exception mid-divide, then reset mid-busy
        unit_op = 2'b01;
        cyc(1, 5'b00111, 5'b01000, 2'b01, '0, 0, '0);
        tick();
        excepttype = 32'h4;
        cyc(1, '0, 5'b11111, '0, 2'b01, 1, 32'hBFC00380);
        excepttype = 0; unit_op = 2'b00;
        cyc(1, '0, '0, '0, '0, 0, '0);
        unit_op = 2'b01;
        cyc(1, 5'b00111, 5'b01000, 2'b01, '0, 0, '0);
        tick();
        resetn = 1'b0;
        cyc(1, '0, '0, '0, '0, 0, '0);
        resetn = 1'b1;
        cyc(1, 5'b00111, 5'b01000, 2'b01, '0, 0, '0);
        unit_ready = 2'b01;
        cyc(1, 5'b00111, 5'b01000, '0, '0, 0, '0);
        unit_ready = 2'b00;
        cyc(1, '0, '0, '0, '0, 0, '0);
        unit_op = 2'b00;
        tick();
        // unit 1 together with load-use, ready on the first busy cycle
        unit_op = 2'b10; ex_rmem = 1; ex_rt = 3; id_rt = 3;
        cyc(1, 5'b00111, 5'b01000, 2'b10, '0, 0, '0);
        unit_ready = 2'b10;
        cyc(1, 5'b00111, 5'b01000, '0, '0, 0, '0);
        unit_ready = 2'b00;
        cyc(1, 5'b00011, 5'b00100, '0, '0, 0, '0);
        unit_op = 2'b00; ex_rmem = 0;
        cyc(1, '0, '0, '0, '0, 0, '0);
        // exception blocked by a stall at or beyond MEM
        excepttype = 32'h4; stall_req = 5'b10000;
        cyc(1, 5'b11111, '0, '0, '0, 0, '0);
        excepttype = 0; stall_req = '0;
        cyc(1, '0, '0, '0, '0, 0, '0);
        // ERET held across an I-bus stall
        excepttype = 32'he; cp0_epc = 32'h80001234; stall_req = 5'b00001;
        cyc(1, '0, 5'b11111, '0, '0, 1, 32'h80001234);
        excepttype = 0;
        repeat (2) cyc(1, '0, 5'b00001, '0, '0, 1, 32'h80001234);
        stall_req = '0;
        cyc(1, '0, 5'b00001, '0, '0, 1, 32'h80001234);
        cyc(1, '0, '0, '0, '0, 0, '0);
        // a second accept while pending overwrites the target
        excepttype = 32'h4; stall_req = 5'b00001;
        cyc(1, '0, 5'b11111, '0, '0, 1, 32'hBFC00380);
        excepttype = 32'he; cp0_epc = 32'h80005678;
        cyc(1, '0, 5'b11111, '0, '0, 1, 32'h80005678);
        excepttype = 0;
        cyc(1, '0, 5'b00001, '0, '0, 1, 32'h80005678);
        stall_req = '0;
        cyc(1, '0, 5'b00001, '0, '0, 1, 32'h80005678);
        cyc(1, '0, '0, '0, '0, 0, '0);
        // mixed stall/exception traffic with units idle
        for (int n = 0; n < 40; n++) begin
            stall_req  = 5'($urandom_range(0, 31)) & (($urandom_range(0, 3) == 0) ? 5'h1f : 5'h07);
            ex_rmem    = 1'($urandom_range(0, 1));
            ex_rt      = 5'($urandom_range(0, 3));
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            excepttype = ($urandom_range(0, 3) == 0) ? 32'h4 : ($urandom_range(0, 5) == 0) ? 32'he : 32'h0;
            cp0_epc    = $urandom;
            tick();
        end
        stall_req = '0; ex_rmem = 0; excepttype = 0;
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised stall/flush controller for the in-order CPU pipeline. Per-stage stall requests, load-use detection at decode, and handshakes with up to NUNIT multicycle execute units (divider, multiplier, ...) are turned into per-stage stall/flush vectors. A per-unit start/busy/done FSM and a held exception-redirect register ensure each multicycle op is started once and each exception redirect reaches the PC even under a fetch-side stall.

## Interface
- NSTAGE, 5, pipeline depth; stage 0 = IF, NSTAGE-1 = WB; legal range 4..8
- ID_STAGE, 1, stage index of decode (load-use detection point)
- EX_STAGE, 2, stage index of execute (multicycle units)
- MEM_STAGE, 3, stage index where exceptions resolve
- NUNIT, 2, number of multicycle units; 1..4
- EXC_VEC, 32'hBFC00380, redirect target for all non-ERET exceptions
- ERET_CODE, 32'h0000000e, excepttype value that selects cp0_epc
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  synchronous active-low reset
- stall_req  in  NSTAGE  per-stage stall request (e.g. bit 0 I-bus wait, bit MEM_STAGE D-bus wait)
- ex_rmem  in  1  instruction in EX is a load
- ex_rt  in  5  load destination register in EX
- id_rs, id_rt  in  5 each  source registers in ID
- unit_op  in  NUNIT  EX holds an op for unit u
- unit_ready  in  NUNIT  unit u result valid (pulse or level)
- excepttype  in  32  exception code from MEM_STAGE; 0 = none
- cp0_epc  in  32  EPC for ERET
- stall  out  NSTAGE  stage i holds its register
- flush  out  NSTAGE  stage i register loads a bubble
- unit_start  out  NUNIT  one-cycle start pulse to unit u
- unit_abort  out  NUNIT  one-cycle abort pulse to unit u
- redirect_valid  out  1  load redirect_pc into PC
- redirect_pc  out  32  redirect target

## Operation
- Stall sources, each with a stage k: stall_req[k] (k), load-use (ID_STAGE) = ex_rmem & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt), unit u stalling (EX_STAGE).
- stall[i] = 1 if any active source has k >= i. flush[i] = 1 when stall[i-1]=1 and stall[i]=0 (bubble insertion), for i>=1.
- Unit FSM per u, states IDLE/BUSY/DONE:
  - IDLE: if unit_op[u] and no exception -> unit_start[u]=1, stalling, next BUSY. Else stay.
  - BUSY: stalling; unit_ready[u] -> DONE, else stay. unit_op dropping in BUSY is illegal.
  - DONE: not stalling; if stall[EX_STAGE]=0 -> IDLE (op leaves EX), else stay in DONE (no restart).
  - unit_ready in IDLE/DONE ignored.
- Exception accept: excepttype!=0 and stall_req[j]=0 for all j>=MEM_STAGE. On accept: flush = all ones, stall = all zeros; any unit in BUSY or DONE -> IDLE, unit_abort[u]=1 for BUSY units; unit_start suppressed; redirect_pc = cp0_epc if excepttype==ERET_CODE else EXC_VEC.
- excepttype!=0 but not accepted: exception ignored this cycle, normal stall logic applies.
- Redirect hold: redirect_valid=1 in the accept cycle. If stall_req[0]=1 in that cycle, pending register latches redirect_pc; redirect_valid and flush[0] stay 1 and stall[0] stays 0 each cycle until first cycle with stall_req[0]=0, then pending clears. New accept while pending overwrites the target.

## Timing
- stall, flush, unit_start, unit_abort, and redirect_valid/pc in the accept cycle are combinational from inputs and FSM state; pending redirect is registered.
- Reset (resetn=0 at edge): FSMs IDLE, pending cleared, redirect_pc register 0. While resetn=0 all outputs forced 0.
- Multicycle op: op in EX at cycle t -> unit_start at t; ready seen at t+n (n>=1) -> DONE at t+n+1, stall[EX_STAGE] released at t+n+1, flush[EX_STAGE+1] at t..t+n.
- Simultaneous: exception beats every stall source; load-use plus unit stall both stall up to EX_STAGE; reset beats everything.

## Test plan
- Load-use: ex_rmem=1, ex_rt=5, id_rs=5 -> stall=5'b00011, flush=5'b00100; ex_rt=0 -> stall=0.
- Divide: unit_op[0]=1 cycle t, ready at t+4 -> unit_start[0] only at t, stall=5'b00111 cycles t..t+4, 0 at t+5, no second start.
- DONE hold: ready at t+2 while stall_req[3]=1 until t+6 -> stall[3:0]=1 through t+6, FSM stays DONE, no restart.
- Exception mid-divide: excepttype=32'h4 at t+2 -> flush=5'b11111, unit_abort[0]=1, redirect_pc=32'hBFC00380, FSM IDLE at t+3.
- ERET under I-bus stall: excepttype=32'he, cp0_epc=32'h80001234, stall_req[0]=1 for 3 cycles -> redirect_valid=1 for 4 cycles with 32'h80001234, drops after stall_req[0]=0.
- Reset mid-BUSY: resetn=0 one edge -> all outputs 0, FSM IDLE, pending cleared.
